// File: rtl/mood_pwm_driver_if.sv
// Mood-to-LED link: mood code toward the driver, three PWM lines,
// busy flag and period-sync pulse back to whoever watches the LED.
interface mood_pwm_driver_if;
    logic [1:0] response;
    logic       red_pwm;
    logic       green_pwm;
    logic       blue_pwm;
    logic       busy;
    logic       pwm_sync;

    modport master (
        output response,
        input  red_pwm,
        input  green_pwm,
        input  blue_pwm,
        input  busy,
        input  pwm_sync
    );

    modport slave (
        input  response,
        output red_pwm,
        output green_pwm,
        output blue_pwm,
        output busy,
        output pwm_sync
    );
endinterface

// File: rtl/mood_pwm_driver.sv
// RGB PWM driver: fades three duty cycles toward a per-mood colour,
// updating duties only at PWM period boundaries so the LED never glitches.
// Ports: clk, reset (sync, active-low), bus (slave: response in;
// red/green/blue_pwm, busy, pwm_sync out).
module mood_pwm_driver #(
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 4,
    parameter int STEP     = 8
) (
    input  logic             clk,
    input  logic             reset,
    mood_pwm_driver_if.slave bus
);
    typedef logic [PWM_BITS-1:0] duty_t;
    typedef enum logic {IDLE, FADING} state_t;

    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam duty_t FULL = '1;
    localparam duty_t HALF = duty_t'(2 ** (PWM_BITS - 1));
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [31:0] STEP_U = 32'(STEP);

    state_t           state;
    state_t           state_nx;
    logic [1:0]       resp_q;
    duty_t            pwm_cnt;
    duty_t            duty_r;
    duty_t            duty_g;
    duty_t            duty_b;
    duty_t            nx_r;
    duty_t            nx_g;
    duty_t            nx_b;
    duty_t            tgt_r;
    duty_t            tgt_g;
    duty_t            tgt_b;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nx;
    logic             boundary;
    logic             at_tgt;
    logic             fade;
    logic             red_q;
    logic             green_q;
    logic             blue_q;
    logic             sync_q;

    // Move one channel toward its target by at most STEP, clamping on
    // arrival. Arithmetic is widened so the distance test cannot wrap.
    function automatic duty_t step_ch(input duty_t duty, input duty_t tgt);
        logic [31:0] du;
        logic [31:0] tg;
        duty_t       res;
        du  = 32'(duty);
        tg  = 32'(tgt);
        res = duty;
        if (tg > du) begin
            res = (tg - du <= STEP_U) ? tgt : duty_t'(du + STEP_U);
        end else if (du > tg) begin
            res = (du - tg <= STEP_U) ? tgt : duty_t'(du - STEP_U);
        end
        return res;
    endfunction

    assign boundary = (pwm_cnt == FULL);
    assign at_tgt   = (duty_r == tgt_r) && (duty_g == tgt_g)
                   && (duty_b == tgt_b);

    always_comb begin
        tgt_r = '0;
        tgt_g = '0;
        tgt_b = '0;
        unique case (resp_q)
            2'b00: ;
            2'b01: begin
                tgt_r = FULL;
                tgt_g = HALF;
            end
            2'b10: tgt_b = FULL;
            2'b11: tgt_r = FULL;
            default: ;
        endcase
    end

    // An IDLE boundary with a pending difference is processed exactly
    // like a FADING boundary, so the first step can land immediately.
    always_comb begin
        state_nx = state;
        div_nx   = div;
        nx_r     = duty_r;
        nx_g     = duty_g;
        nx_b     = duty_b;
        fade     = 1'b0;
        unique case (state)
            IDLE:    fade = boundary && !at_tgt;
            FADING:  fade = boundary;
            default: fade = 1'b0;
        endcase
        if (fade) begin
            if (div == DIV_LAST) begin
                nx_r   = step_ch(duty_r, tgt_r);
                nx_g   = step_ch(duty_g, tgt_g);
                nx_b   = step_ch(duty_b, tgt_b);
                div_nx = '0;
            end else begin
                div_nx = div + 1'b1;
            end
            if ((nx_r == tgt_r) && (nx_g == tgt_g) && (nx_b == tgt_b)) begin
                state_nx = IDLE;
                div_nx   = '0;
            end else begin
                state_nx = FADING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_q  <= 2'b00;
            pwm_cnt <= '0;
            div     <= '0;
            duty_r  <= '0;
            duty_g  <= '0;
            duty_b  <= '0;
            red_q   <= 1'b0;
            green_q <= 1'b0;
            blue_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            resp_q  <= bus.response;
            pwm_cnt <= pwm_cnt + 1'b1;
            div     <= div_nx;
            duty_r  <= nx_r;
            duty_g  <= nx_g;
            duty_b  <= nx_b;
            red_q   <= (pwm_cnt < duty_r);
            green_q <= (pwm_cnt < duty_g);
            blue_q  <= (pwm_cnt < duty_b);
            sync_q  <= (pwm_cnt == '0);
        end
    end

    assign bus.red_pwm   = red_q;
    assign bus.green_pwm = green_q;
    assign bus.blue_pwm  = blue_q;
    assign bus.pwm_sync  = sync_q;
    assign bus.busy      = (state == FADING);
endmodule

// File: tb/tb_mood_pwm_driver.sv
// Directed bench for mood_pwm_driver: period-by-period duty table plus
// reset, glitch and slow-divider sequences. Two DUTs (FADE_DIV 1 and 3).
module tb_mood_pwm_driver;
    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    bit   sel;

    always #5 clk = ~clk;

    mood_pwm_driver_if if1();
    mood_pwm_driver_if if3();

    mood_pwm_driver #(.PWM_BITS(4), .FADE_DIV(1), .STEP(4)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1)
    );

    mood_pwm_driver #(.PWM_BITS(4), .FADE_DIV(3), .STEP(4)) dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (if3)
    );

    logic m_r;
    logic m_g;
    logic m_b;
    logic m_busy;
    logic m_sync;

    assign m_r    = sel ? if3.red_pwm   : if1.red_pwm;
    assign m_g    = sel ? if3.green_pwm : if1.green_pwm;
    assign m_b    = sel ? if3.blue_pwm  : if1.blue_pwm;
    assign m_busy = sel ? if3.busy      : if1.busy;
    assign m_sync = sel ? if3.pwm_sync  : if1.pwm_sync;

    typedef struct {
        logic [1:0] resp;
        logic       glitch;
        logic [1:0] gval;
        int         er;
        int         eg;
        int         eb;
        logic       busy;
    } vec_t;

    localparam int N1 = 26;
    localparam int N3 = 7;

    vec_t vecs[N1+N3];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int v5(input logic [4:0] x);
        return $isunknown(x) ? -1 : int'(x);
    endfunction

    function automatic int mask_of(input int d);
        return (1 << d) - 1;
    endfunction

    task automatic set_resp(input logic [1:0] v);
        if (sel) if3.response = v;
        else if1.response = v;
    endtask

    // Entered at the negedge of a pwm_sync cycle; leaves at the next one.
    task automatic run_row(input int idx, input vec_t v);
        int mr;
        int mg;
        int mb;
        int extra;
        mr    = 0;
        mg    = 0;
        mb    = 0;
        extra = 0;
        set_resp(v.resp);
        chk($sformatf("row%0d busy", idx), v5({4'b0, m_busy}), int'(v.busy));
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (m_r) mr |= (1 << i);
            if (m_g) mg |= (1 << i);
            if (m_b) mb |= (1 << i);
            if (i > 0 && m_sync) extra++;
            if (v.glitch && i == 4) set_resp(v.gval);
            if (v.glitch && i == 8) set_resp(v.resp);
        end
        @(negedge clk);
        chk($sformatf("row%0d extra_sync", idx), extra, 0);
        chk($sformatf("row%0d next_sync", idx), v5({4'b0, m_sync}), 1);
        chk($sformatf("row%0d red_mask", idx), mr, mask_of(v.er));
        chk($sformatf("row%0d green_mask", idx), mg, mask_of(v.eg));
        chk($sformatf("row%0d blue_mask", idx), mb, mask_of(v.eb));
    endtask

    initial begin
        int bad;
        int syncs;
        // resp, glitch, gval, R, G, B, busy
        vecs[0]  = '{2'b11, 1'b0, 2'b00,  0, 0,  0, 1'b0};
        vecs[1]  = '{2'b11, 1'b0, 2'b00,  4, 0,  0, 1'b1};
        vecs[2]  = '{2'b11, 1'b0, 2'b00,  8, 0,  0, 1'b1};
        vecs[3]  = '{2'b11, 1'b0, 2'b00, 12, 0,  0, 1'b1};
        vecs[4]  = '{2'b11, 1'b0, 2'b00, 15, 0,  0, 1'b0};
        vecs[5]  = '{2'b11, 1'b0, 2'b00, 15, 0,  0, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 2'b00, 15, 0,  0, 1'b0};
        vecs[7]  = '{2'b01, 1'b0, 2'b00, 15, 4,  0, 1'b1};
        vecs[8]  = '{2'b01, 1'b0, 2'b00, 15, 8,  0, 1'b0};
        vecs[9]  = '{2'b01, 1'b0, 2'b00, 15, 8,  0, 1'b0};
        vecs[10] = '{2'b00, 1'b0, 2'b00, 15, 8,  0, 1'b0};
        vecs[11] = '{2'b00, 1'b0, 2'b00, 11, 4,  0, 1'b1};
        vecs[12] = '{2'b00, 1'b0, 2'b00,  7, 0,  0, 1'b1};
        vecs[13] = '{2'b00, 1'b0, 2'b00,  3, 0,  0, 1'b1};
        vecs[14] = '{2'b00, 1'b0, 2'b00,  0, 0,  0, 1'b0};
        vecs[15] = '{2'b11, 1'b0, 2'b00,  0, 0,  0, 1'b0};
        vecs[16] = '{2'b11, 1'b0, 2'b00,  4, 0,  0, 1'b1};
        vecs[17] = '{2'b10, 1'b0, 2'b00,  8, 0,  0, 1'b1};
        vecs[18] = '{2'b10, 1'b0, 2'b00,  4, 0,  4, 1'b1};
        vecs[19] = '{2'b10, 1'b0, 2'b00,  0, 0,  8, 1'b1};
        vecs[20] = '{2'b10, 1'b0, 2'b00,  0, 0, 12, 1'b1};
        vecs[21] = '{2'b10, 1'b0, 2'b00,  0, 0, 15, 1'b0};
        vecs[22] = '{2'b10, 1'b1, 2'b11,  0, 0, 15, 1'b0};
        vecs[23] = '{2'b10, 1'b0, 2'b00,  0, 0, 15, 1'b0};
        vecs[24] = '{2'b11, 1'b0, 2'b00,  0, 0, 15, 1'b0};
        vecs[25] = '{2'b11, 1'b0, 2'b00,  4, 0, 11, 1'b1};
        vecs[26] = '{2'b11, 1'b0, 2'b00,  0, 0,  0, 1'b0};
        vecs[27] = '{2'b11, 1'b0, 2'b00,  0, 0,  0, 1'b1};
        vecs[28] = '{2'b11, 1'b0, 2'b00,  0, 0,  0, 1'b1};
        vecs[29] = '{2'b11, 1'b0, 2'b00,  4, 0,  0, 1'b1};
        vecs[30] = '{2'b11, 1'b0, 2'b00,  4, 0,  0, 1'b1};
        vecs[31] = '{2'b11, 1'b0, 2'b00,  4, 0,  0, 1'b1};
        vecs[32] = '{2'b11, 1'b0, 2'b00,  8, 0,  0, 1'b1};

        sel          = 1'b0;
        rst1         = 1'b0;
        rst3         = 1'b0;
        if1.response = 2'b11;
        if3.response = 2'b11;

        // Outputs held low while reset is asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset_hold%0d", i),
                v5({if1.red_pwm, if1.green_pwm, if1.blue_pwm,
                    if1.busy, if1.pwm_sync}), 0);
        end

        // First period starts the cycle after release.
        rst1 = 1'b1;
        @(negedge clk);
        chk("first_sync", v5({4'b0, m_sync}), 1);
        for (int i = 0; i < N1; i++) run_row(i, vecs[i]);

        // Reset mid-fade, red currently at duty 8.
        repeat (5) @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        chk("midfade_reset",
            v5({if1.red_pwm, if1.green_pwm, if1.blue_pwm,
                if1.busy, if1.pwm_sync}), 0);
        if1.response = 2'b00;
        @(negedge clk);
        chk("midfade_reset2",
            v5({if1.red_pwm, if1.green_pwm, if1.blue_pwm,
                if1.busy, if1.pwm_sync}), 0);
        rst1  = 1'b1;
        bad   = 0;
        syncs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (v5({if1.red_pwm, if1.green_pwm, if1.blue_pwm,
                    if1.busy, 1'b0}) != 0) bad++;
            if (if1.pwm_sync) syncs++;
        end
        chk("post_reset_dark", bad, 0);
        chk("post_reset_syncs", syncs, 3);

        // Slow divider: one step every three periods.
        sel  = 1'b1;
        rst3 = 1'b1;
        @(negedge clk);
        chk("div3_first_sync", v5({4'b0, m_sync}), 1);
        for (int i = N1; i < N1 + N3; i++) run_row(i, vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
